n_clic_irq_in: RTL and testbench

External interrupt front-end feeding `n_clic` pend requests. Synchronizes asynchronous `irq_in` lines, optionally debounces them, detects edge or level events per line, latches them as pending, and presents one pend request at a time to `n_clic` over a valid/ready handshake. `n_clic` then sets the pend bit of entry `FirstVec + line`. Per-line configuration is a CSR bank on the core CSR bus.

---
 rtl/n_clic_irq_in.sv | 249 ++++++++++++++++++++++++
 tb/tb_n_clic_irq_in.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/n_clic_irq_in.sv
// n_clic_irq_in: external interrupt front-end for n_clic.
// Synchronizes raw irq lines, optionally debounces them, detects edge/level
// events, latches them as pending and hands one pend request at a time to
// n_clic over a valid/ready pair. Per-line config lives in a small CSR bank.
//
// Build option: define IRQ_DEBOUNCE_EN to include the per-line debounce
// counters and the thr config field. Without it the filtered value is the
// synchronized value and thr reads as zero.
//
// Config word layout (line k at CfgBase + k):
//   bit0 en, bit1 edge mode, bit2 inv, bit3 ovr (sticky, read-only),
//   bits[4 +: DebounceWidth] thr (debounce builds only).
//
// csr_op encoding follows the RISC-V funct3 field: bit2 selects the 5-bit
// immediate operand, bits[1:0] = 01 write, 10 set, 11 clear. Set/clear with
// a zero operand is a pure read and does not touch the word (so a read does
// not clear ovr).
module n_clic_irq_in #(
    parameter int                      IrqNum        = 4,
    parameter int                      SyncStages    = 2,
    parameter int                      DebounceWidth = 8,
    parameter int                      FirstVec      = 4,
    parameter int                      VecSize       = 16,
    parameter int                      XLen          = 32,
    parameter int                      CsrAddrWidth  = 12,
    parameter logic [CsrAddrWidth-1:0] CfgBase       = 12'h7C0,
    parameter int                      VecWidth      = $clog2(VecSize)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IrqNum-1:0]       irq_in,
    input  logic                    csr_enable,
    input  logic [CsrAddrWidth-1:0] csr_addr,
    input  logic [2:0]              csr_op,
    input  logic [4:0]              rs1_zimm,
    input  logic [XLen-1:0]         rs1_data,
    output logic [XLen-1:0]         csr_out,
    output logic                    pend_valid,
    output logic [VecWidth-1:0]     pend_vec,
    input  logic                    pend_ready
);

    // ------------------------------------------------------------------
    // CSR bank decode
    // ------------------------------------------------------------------
    logic [CsrAddrWidth-1:0] csr_idx;
    logic                    csr_hit;
    logic [XLen-1:0]         csr_operand;
    logic [XLen-1:0]         csr_wdata;
    logic                    csr_wr;
    logic [XLen-1:0]         cfg_word [IrqNum];

    // Address offset into the bank; wraps for addresses below CfgBase so
    // they fail the range test.
    assign csr_idx = csr_addr - CfgBase;
    assign csr_hit = (csr_idx < CsrAddrWidth'(IrqNum));

    // Read mux: the selected line's current (pre-write) config word.
    always_comb begin
        csr_out = '0;
        for (int k = 0; k < IrqNum; k++) begin
            if (csr_hit && (csr_idx == CsrAddrWidth'(k))) begin
                csr_out = cfg_word[k];
            end
        end
    end

    // Write value and write strobe for the addressed word.
    always_comb begin
        csr_operand = csr_op[2] ? {{(XLen-5){1'b0}}, rs1_zimm} : rs1_data;
        case (csr_op[1:0])
            2'b01:   csr_wdata = csr_operand;
            2'b10:   csr_wdata = csr_out | csr_operand;
            2'b11:   csr_wdata = csr_out & ~csr_operand;
            default: csr_wdata = csr_out;
        endcase
        csr_wr = csr_enable && csr_hit &&
                 ((csr_op[1:0] == 2'b01) ||
                  ((csr_op[1:0] != 2'b00) && (csr_operand != '0)));
    end

    // ------------------------------------------------------------------
    // Per-line front end
    // ------------------------------------------------------------------
    logic [IrqNum-1:0] pend_bits;
    logic [IrqNum-1:0] load_sel;

    genvar gi;
    generate
        for (gi = 0; gi < IrqNum; gi++) begin : g_line
            logic                  line_wr;
            logic [SyncStages-1:0] sync_reg;
            logic                  s_val;
            logic                  filt;
            logic                  filt_q_reg;
            logic                  filt_prev_reg;
            logic                  en_reg;
            logic                  edge_mode_reg;
            logic                  inv_reg;
            logic                  ovr_reg;
            logic                  pend_reg;
            logic                  edge_evt;
            logic                  evt;
            logic                  pend_next;

            assign line_wr = csr_wr && (csr_idx == CsrAddrWidth'(gi));

            // Synchronizer chain; oldest sample at the top bit.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SyncStages-2:0], irq_in[gi]};
                end
            end

            assign s_val = sync_reg[SyncStages-1] ^ inv_reg;

`ifdef IRQ_DEBOUNCE_EN
            logic [DebounceWidth-1:0] thr_reg;
            logic [DebounceWidth-1:0] cnt_reg;
            logic                     filt_reg;

            // Debounce: follow s only after it has differed from the
            // filtered value for thr+1 consecutive cycles.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg  <= '0;
                    filt_reg <= 1'b0;
                end else if (s_val == filt_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == thr_reg) begin
                    cnt_reg  <= '0;
                    filt_reg <= s_val;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // Threshold field, updated by CSR writes to this line.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    thr_reg <= '0;
                end else if (line_wr) begin
                    thr_reg <= csr_wdata[4 +: DebounceWidth];
                end
            end

            assign filt = filt_reg;
            assign cfg_word[gi] = {{(XLen-4-DebounceWidth){1'b0}}, thr_reg,
                                   ovr_reg, inv_reg, edge_mode_reg, en_reg};
`else
            assign filt = s_val;
            assign cfg_word[gi] = {{(XLen-4){1'b0}},
                                   ovr_reg, inv_reg, edge_mode_reg, en_reg};
`endif

            // Event stage: registered filtered value plus its previous
            // sample for rising-edge detection.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    filt_q_reg    <= 1'b0;
                    filt_prev_reg <= 1'b0;
                end else begin
                    filt_q_reg    <= filt;
                    filt_prev_reg <= filt_q_reg;
                end
            end

            // Level events re-arm as soon as the pending flag is consumed.
            assign edge_evt  = filt_q_reg & ~filt_prev_reg;
            assign evt       = edge_mode_reg ? edge_evt : (filt_q_reg & ~pend_reg);
            // A fresh event beats the arbiter's clear; disabling drops it.
            assign pend_next = en_reg & ((pend_reg & ~load_sel[gi]) | evt);

            // Config bits; a write clears the sticky overrun flag.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    en_reg        <= 1'b0;
                    edge_mode_reg <= 1'b0;
                    inv_reg       <= 1'b0;
                    ovr_reg       <= 1'b0;
                end else if (line_wr) begin
                    en_reg        <= csr_wdata[0];
                    edge_mode_reg <= csr_wdata[1];
                    inv_reg       <= csr_wdata[2];
                    ovr_reg       <= 1'b0;
                end else if (edge_mode_reg && edge_evt && pend_reg) begin
                    ovr_reg <= 1'b1;
                end
            end

            // Pending flag.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pend_reg <= 1'b0;
                end else begin
                    pend_reg <= pend_next;
                end
            end

            assign pend_bits[gi] = pend_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Fixed-priority arbiter and output register
    // ------------------------------------------------------------------
    logic                pend_valid_reg;
    logic [VecWidth-1:0] pend_vec_reg;
    logic [IrqNum-1:0]   pick;
    logic [VecWidth-1:0] pick_idx;
    logic                pick_found;
    logic                take;

    // Lowest pending line wins; the output register refills when empty or
    // being accepted this cycle.
    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < IrqNum; k++) begin
            if (!pick_found && pend_bits[k]) begin
                pick_found = 1'b1;
                pick[k]    = 1'b1;
                pick_idx   = VecWidth'(k);
            end
        end
        take     = !pend_valid_reg || pend_ready;
        load_sel = take ? pick : '0;
    end

    // Output register: holds a presented request stable until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid_reg <= 1'b0;
            pend_vec_reg   <= '0;
        end else if (take) begin
            pend_valid_reg <= pick_found;
            if (pick_found) begin
                pend_vec_reg <= VecWidth'(FirstVec) + pick_idx;
            end
        end
    end

    assign pend_valid = pend_valid_reg;
    assign pend_vec   = pend_vec_reg;

endmodule

// File: tb/tb_n_clic_irq_in.sv
// Directed testbench for n_clic_irq_in (default parameters, FirstVec = 4).
// Covers both IRQ_DEBOUNCE_EN builds.
module tb_n_clic_irq_in;

    localparam logic [11:0] CfgBase = 12'h7C0;
    localparam logic [2:0]  OpRw    = 3'b001;
`ifdef IRQ_DEBOUNCE_EN
    localparam int Lat = 5;   // SyncStages + thr(0) + 3
`else
    localparam int Lat = 4;   // SyncStages + 2
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  irq_in = 4'b0000;
    logic        csr_enable = 1'b0;
    logic [11:0] csr_addr = 12'h000;
    logic [2:0]  csr_op = 3'b000;
    logic [4:0]  rs1_zimm = 5'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] csr_out;
    logic        pend_valid;
    logic [3:0]  pend_vec;
    logic        pend_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int req_cnt = 0;

    n_clic_irq_in dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .csr_enable (csr_enable),
        .csr_addr   (csr_addr),
        .csr_op     (csr_op),
        .rs1_zimm   (rs1_zimm),
        .rs1_data   (rs1_data),
        .csr_out    (csr_out),
        .pend_valid (pend_valid),
        .pend_vec   (pend_vec),
        .pend_ready (pend_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_count(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (pend_valid) req_cnt++;
        end
    endtask

    task automatic csr_write(input int line, input logic [31:0] val);
        csr_enable = 1'b1;
        csr_addr   = CfgBase + 12'(line);
        csr_op     = OpRw;
        rs1_data   = val;
        tick();
        csr_enable = 1'b0;
        csr_op     = 3'b000;
    endtask

    task automatic csr_read(input int line, output logic [31:0] v);
        csr_addr = CfgBase + 12'(line);
        #1;
        v = csr_out;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!pend_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, pend_valid, 1);
    endtask

    task automatic pulse(input int line, input int hi, input int lo);
        irq_in[line] = 1'b1;
        repeat (hi) tick();
        irq_in[line] = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          adj;
        int          bad_vec;
        logic        prev_v;

        // ---------------- reset state ----------------
        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_valid", pend_valid, 0);
        check("rst_vec", pend_vec, 0);
        csr_read(0, v);
        check("rst_cfg0", v, 0);
        tick();
        reset = 1'b1;
        tick();

        // ---------------- edge, line 0, latency ----------------
        csr_write(0, 32'h3);
        pend_ready = 1'b1;
        irq_in[0]  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 2) irq_in[0] = 1'b0;
            check($sformatf("edge_valid_c%0d", i), pend_valid, (i == Lat) ? 1 : 0);
            if (i == Lat) check("edge_vec", pend_vec, 4);
        end

        // ---------------- lines 1 and 3 together, backpressure ----------------
        pend_ready = 1'b0;
        csr_write(1, 32'h3);
        csr_write(3, 32'h3);
        irq_in[1] = 1'b1;
        irq_in[3] = 1'b1;
        wait_valid("pair_wait", 20);
        check("pair_vec_h0", pend_vec, 5);
        for (int j = 1; j < 5; j++) begin
            tick();
            check($sformatf("pair_valid_h%0d", j), pend_valid, 1);
            check($sformatf("pair_vec_h%0d", j), pend_vec, 5);
        end
        pend_ready = 1'b1;
        irq_in[1]  = 1'b0;
        irq_in[3]  = 1'b0;
        tick();
        check("pair_valid_2nd", pend_valid, 1);
        check("pair_vec_2nd", pend_vec, 7);
        tick();
        check("pair_valid_done", pend_valid, 0);

        // ---------------- level, inv=1, line 2 ----------------
        irq_in[2] = 1'b1;
        csr_write(2, 32'h4);        // inv only, disabled while settling
        repeat (6) tick();
        csr_write(2, 32'h5);        // en + inv, level mode
        irq_in[2] = 1'b0;           // active (low)
        req_cnt = 0;
        adj     = 0;
        bad_vec = 0;
        prev_v  = 1'b0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (i == 19) irq_in[2] = 1'b1;
            if (pend_valid) begin
                req_cnt++;
                if (prev_v) adj++;
                if (pend_vec != 4'd6) bad_vec++;
            end
            prev_v = pend_valid;
        end
        check("level_requests", req_cnt, 10);
        check("level_back_to_back", adj, 0);
        check("level_bad_vec", bad_vec, 0);
        check("level_idle_after", pend_valid, 0);

        // ---------------- overrun on line 2 ----------------
        csr_write(2, 32'h0);
        irq_in[2] = 1'b0;
        repeat (6) tick();
        csr_write(2, 32'h3);
        pend_ready = 1'b0;
        pulse(0, 3, 0);
        wait_valid("ovr_hold_wait", 20);
        check("ovr_hold_vec", pend_vec, 4);
        pulse(2, 3, 6);
        csr_read(2, v);
        check("ovr_after_first", v, 32'h3);
        pulse(2, 3, 6);
        csr_read(2, v);
        check("ovr_after_second", v, 32'hB);
        csr_enable = 1'b1;
        csr_addr   = CfgBase + 12'd2;
        csr_op     = OpRw;
        rs1_data   = 32'h3;
        #1;
        check("ovr_prewrite_read", csr_out, 32'hB);
        tick();
        csr_enable = 1'b0;
        csr_op     = 3'b000;
        check("ovr_cleared", csr_out, 32'h3);

        // ---------------- async reset mid-handshake ----------------
        check("arst_before_valid", pend_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", pend_valid, 0);
        check("arst_vec", pend_vec, 0);
        for (int k = 0; k < 4; k++) begin
            csr_addr = CfgBase + 12'(k);
            #1;
            check($sformatf("arst_cfg%0d", k), csr_out, 0);
        end
        tick();
        tick();
        reset    = 1'b1;
        csr_addr = 12'h000;
        tick();

        // ---------------- debounce ----------------
        pend_ready = 1'b1;
        csr_write(1, 32'h43);
        csr_read(1, v);
        req_cnt = 0;
`ifdef IRQ_DEBOUNCE_EN
        check("deb_cfg_read", v, 32'h43);
        for (int g = 1; g <= 4; g++) begin
            irq_in[1] = 1'b1;
            tick_count(g);
            irq_in[1] = 1'b0;
            tick_count(12);
        end
        check("deb_glitch_requests", req_cnt, 0);
        irq_in[1] = 1'b1;
        tick_count(6);
        irq_in[1] = 1'b0;
        tick_count(20);
        check("deb_pulse_requests", req_cnt, 1);
`else
        check("deb_cfg_read", v, 32'h3);
        irq_in[1] = 1'b1;
        tick_count(1);
        irq_in[1] = 1'b0;
        tick_count(12);
        check("deb_glitch_requests", req_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
